// File: rtl/axi_read_master_if.sv
// AXI4 read-address and read-data channels shared between the read master and its slave.
interface axi_read_master_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 8
);
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;

    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_read_master.sv
// Single-burst AXI4 read initiator: one INCR burst per command, beats returned through a
// one-entry registered valid/ready stream with done pulse and sticky error status.
module axi_read_master #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     areset,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,

    axi_read_master_if.master        axi,

    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,

    output logic                     done,
    output logic                     error,
    output logic [8:0]               beats_received
);

    localparam int unsigned MaxSize = $clog2(STROBE_WIDTH);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               len_q, len_d;
    logic [2:0]               size_q, size_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [8:0]               beats_q, beats_d;
    logic                     exp_last;

    assign axi.araddr     = addr_q;
    assign axi.arlen      = len_q;
    assign axi.arsize     = size_q;
    assign axi.arburst    = 2'b01;
    assign out_data       = data_q;
    assign out_last       = last_q;
    assign out_valid      = valid_q;
    assign done           = done_q;
    assign error          = error_q;
    assign beats_received = beats_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        error_d     = error_q;
        beats_d     = beats_q;
        cmd_ready   = (state_q == StIdle) && !areset;
        axi.arvalid = (state_q == StAddr);
        axi.rready  = 1'b0;
        exp_last    = (beats_q == {1'b0, len_q});

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    size_d  = cmd_size;
                    error_d = 1'b0;
                    beats_d = 9'd0;
                    // Oversized beats cannot be carried on this bus: fail without touching AR.
                    if (32'(cmd_size) > MaxSize) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (axi.arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                axi.rready = !valid_q || out_ready;
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                end
                if (axi.rvalid && axi.rready) begin
                    data_d  = axi.rdata;
                    valid_d = 1'b1;
                    last_d  = axi.rlast || exp_last;
                    if (beats_q != 9'd256) begin
                        beats_d = beats_q + 9'd1;
                    end
                    if ((axi.rresp != 2'b00) || (axi.rlast != exp_last)) begin
                        error_d = 1'b1;
                    end
                    // Whichever of slave rlast or our own count comes first closes the burst.
                    if (axi.rlast || exp_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (valid_q && out_ready && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            error_q <= error_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: doc/axi_read_master.md
# axi_read_master

Single-burst AXI4 read initiator. It accepts a read command (address, beat count, beat size), issues one INCR burst on the AR channel, and collects the R beats. Returned data goes out on a registered valid/ready stream with a last marker, and the block reports completion and error status. It sits opposite the AXI slave RAM on the same bus and serves as the read engine for DMA/test traffic.

## Interface
- DATA_WIDTH, 32, R data width in bits (multiple of 8)
- STROBE_WIDTH, DATA_WIDTH/8, bytes per data word
- ADDRESS_WIDTH, 8, byte address width
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDRESS_WIDTH  burst start byte address
- cmd_len  in  8  beats minus 1 (AXI encoding)
- cmd_size  in  3  log2(bytes per beat)
- araddr  out  ADDRESS_WIDTH  AR address
- arlen  out  8  AR length
- arsize  out  3  AR size
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_WIDTH  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- out_data  out  DATA_WIDTH  returned beat
- out_last  out  1  final beat of burst
- out_valid  out  1  output stream valid
- out_ready  in  1  output stream ready
- done  out  1  one-cycle pulse at command completion
- error  out  1  sticky status for last command
- beats_received  out  9  R beats accepted in current/last command

## Operation
- States: IDLE, ADDR, DATA, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, the block latches addr/len/size, clears error and beats_received, and then:
  - cmd_size > log2(STROBE_WIDTH): no AR is issued. Set error=1, pulse done next cycle, stay IDLE.
  - Otherwise go to ADDR.
- ADDR: arvalid=1; araddr/arlen/arsize equal the latched values and are held stable until arready. On arvalid&&arready, go to DATA.
- DATA: rready = !out_valid || out_ready (one-entry output register).
  - Each rvalid&&rready beat loads out_data, sets out_valid, and increments beats_received.
  - Expected last beat: beats_received == len (before increment).
  - The burst ends on the first accepted beat with rlast=1 or expected-last. That beat carries out_last=1, and the state goes to DRAIN.
  - error is set if rresp != 2'b00 on any beat, or if rlast differs from expected-last on any beat.
- DRAIN: rready=0. When out_valid&&out_ready&&out_last, clear out_valid, pulse done, go to IDLE.
- out_valid clears on out_ready when there is no new beat in the same cycle. A simultaneous consume and new beat reloads the register and keeps out_valid=1.
- rready=0 in IDLE, ADDR, DRAIN. Beats beyond the end of a burst are never accepted.
- beats_received is 9 bits and saturates at 256.
- error and beats_received hold their values until the next command is accepted.

## Timing
- Reset (areset high at edge): state IDLE; arvalid, rready, out_valid, out_last, done, error all 0; beats_received 0; out_data 0; araddr/arlen/arsize 0.
- While areset is high, cmd_ready=0; it rises the cycle after areset falls.
- Command accepted at edge N → arvalid=1 from N+1.
- AR handshake at edge M → rready may be 1 from M+1.
- R beat accepted at edge K → out_valid/out_data valid from K+1.
- Sustained throughput is 1 beat/cycle while out_ready=1.
- Last beat consumed at edge L → done=1 during cycle L+1 and cmd_ready=1 from L+1.
- Reset mid-burst aborts immediately to IDLE with no done pulse. The slave shares aclk and is reset together with this block.

## Test plan
- Reset: hold areset 3 cycles → every output at its reset value; cmd_ready 0 during reset, 1 the cycle after release.
- Aligned burst against the slave RAM (ram[i]=i): cmd_addr=0x10, cmd_len=3, cmd_size=2, out_ready=1 → AR: araddr 0x10, arlen 3, arsize 2, arburst 1. Output: 0x13121110, 0x17161514, 0x1B1A1918, 0x1F1E1D1C, out_last on the 4th only. done one cycle; error 0; beats_received 4.
- Backpressure: same command with out_ready toggled 1/0 every cycle → identical data order; no beat lost or duplicated; rready=0 whenever out_valid&&!out_ready.
- Illegal size: cmd_size=3 with DATA_WIDTH=32 → arvalid never rises; error=1; done pulses once; back in IDLE.
- Error response / early last (bench slave model): len=3, beat 1 returns rresp=2'b10 → error=1, all 4 beats still delivered. Separately, len=3 with rlast on beat 2 → out_last on beat 2, error=1, beats_received 2, done.
- Reset mid-burst: assert areset after 2 of 4 beats → next edge IDLE with outputs at reset values; a following command (0x00, len 0, size 2) returns 0x03020100 with error 0.
